// File: rtl/upsample_pkg.sv
// Shared definitions for the 2x horizontal chroma upsampler: FSM states and
// default widths/limits.
package upsample_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int STALL_LIMIT_DEF = 16;

    typedef enum logic [2:0] {
        EMPTY = 3'd0,
        OUT0  = 3'd1,
        NEED  = 3'd2,
        OUT1  = 3'd3,
        OUT1L = 3'd4
    } state_t;

endpackage

// File: rtl/upsample_avg.sv
// Rounding average of two samples, (a+b+1)>>1, carried at DATA_W+1 bits so
// the sum never wraps before the shift.
module upsample_avg #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    assign y = DATA_W'(({1'b0, a} + {1'b0, b} + (DATA_W+1)'(1)) >> 1);

endmodule

// File: rtl/upsample_h2_axis.sv
// Horizontal 2x chroma upsampler on AXI-Stream: each input sample is emitted
// followed by the rounded average with its neighbour; the last one is replicated.
//
// state | meaning
// ------+--------------------------------------------------------------
// EMPTY | no sample held; accept the first sample of a line into cur
// OUT0  | present cur
// NEED  | cur already sent; accept the following sample into nxt
// OUT1  | present avg(cur, nxt); then nxt becomes cur
// OUT1L | present replicated cur with tlast; line complete
module upsample_h2_axis
    import upsample_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int STALL_LIMIT = STALL_LIMIT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    output logic              m_tlast,
    input  logic              m_tready,
    output logic              block
);

    localparam int              CNT_W = $clog2(STALL_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

    state_t            state, state_next;
    logic [DATA_W-1:0] cur, nxt, avg_data;
    logic              cur_last, nxt_last;
    logic              load_cur, load_nxt, advance;
    logic              s_hs, m_hs;
    logic [CNT_W-1:0]  stall_cnt, stall_cnt_next;
    logic              block_q;

    upsample_avg #(.DATA_W(DATA_W)) u_avg (
        .a (cur),
        .b (nxt),
        .y (avg_data)
    );

    assign s_hs = s_tvalid && s_tready;
    assign m_hs = m_tvalid && m_tready;

    // Outputs are pure functions of state, so s_tready never sees m_tready.
    always_comb begin
        state_next = state;
        s_tready   = 1'b0;
        m_tvalid   = 1'b0;
        m_tdata    = cur;
        m_tlast    = 1'b0;
        load_cur   = 1'b0;
        load_nxt   = 1'b0;
        advance    = 1'b0;
        case (state)
            EMPTY: begin
                s_tready = 1'b1;
                if (s_hs) begin
                    load_cur   = 1'b1;
                    state_next = OUT0;
                end
            end
            OUT0: begin
                m_tvalid = 1'b1;
                if (m_hs) state_next = cur_last ? OUT1L : NEED;
            end
            NEED: begin
                s_tready = 1'b1;
                if (s_hs) begin
                    load_nxt   = 1'b1;
                    state_next = OUT1;
                end
            end
            OUT1: begin
                m_tvalid = 1'b1;
                m_tdata  = avg_data;
                if (m_hs) begin
                    advance    = 1'b1;
                    state_next = OUT0;
                end
            end
            OUT1L: begin
                m_tvalid = 1'b1;
                m_tlast  = 1'b1;
                if (m_hs) state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        stall_cnt_next = '0;
        if (m_tvalid && !m_tready)
            stall_cnt_next = (stall_cnt == LIMIT) ? stall_cnt : stall_cnt + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= EMPTY;
            cur       <= '0;
            nxt       <= '0;
            cur_last  <= 1'b0;
            nxt_last  <= 1'b0;
            stall_cnt <= '0;
            block_q   <= 1'b0;
        end else begin
            state     <= state_next;
            stall_cnt <= stall_cnt_next;
            block_q   <= (stall_cnt_next == LIMIT);
            if (load_cur) begin
                cur      <= s_tdata;
                cur_last <= s_tlast;
            end
            if (load_nxt) begin
                nxt      <= s_tdata;
                nxt_last <= s_tlast;
            end
            if (advance) begin
                cur      <= nxt;
                cur_last <= nxt_last;
            end
        end
    end

    assign block = block_q;

endmodule
